// File: rtl/mprj_seq_monitor.sv
// Checkpoint-sequence monitor: matches a sampled GPIO field in order against a
// programmed (value, mask) table, with per-checkpoint hold and a global budget.
module mprj_seq_monitor #(
  parameter int                WIDTH   = 16,
  parameter int                DEPTH   = 8,
  parameter int                HOLD    = 2,
  parameter int                CNT_W   = 24,
  parameter logic [CNT_W-1:0]  TIMEOUT = 24'd150000
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     cfg_we,
  input  logic [$clog2(DEPTH)-1:0] cfg_addr,
  input  logic [WIDTH-1:0]         cfg_value,
  input  logic [WIDTH-1:0]         cfg_mask,
  input  logic [$clog2(DEPTH):0]   cfg_len,
  input  logic                     start,
  input  logic                     abort,
  input  logic [WIDTH-1:0]         sample_in,
  input  logic                     sample_valid,
  output logic                     busy,
  output logic                     pass,
  output logic                     fail,
  output logic [1:0]               fail_code,
  output logic [$clog2(DEPTH):0]   step,
  output logic [CNT_W-1:0]         cycles
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = AW + 1;
  localparam int HW = $clog2(HOLD + 1);

  localparam logic [SW-1:0]    DEPTH_L = SW'(DEPTH);
  localparam logic [CNT_W-1:0] TO_LAST = TIMEOUT - CNT_W'(1);
  localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD - 1);

  localparam logic [1:0] CODE_TIMEOUT = 2'd1;
  localparam logic [1:0] CODE_ABORT   = 2'd2;
  localparam logic [1:0] CODE_BADCFG  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PASS,
    S_FAIL
  } state_t;

  state_t          state;
  logic [HW-1:0]   hold_cnt;
  logic [SW-1:0]   len_q;

  // Table is deliberately not reset so a bring-up program survives wb_rst_i.
  logic [WIDTH-1:0] tab_val  [DEPTH];
  logic [WIDTH-1:0] tab_mask [DEPTH];

  always_ff @(posedge wb_clk_i) begin
    if (cfg_we && (state != S_RUN)) begin
      tab_val[cfg_addr]  <= cfg_value & cfg_mask;
      tab_mask[cfg_addr] <= cfg_mask;
    end
  end

  // sample_valid is a pure qualifier: there is no back-pressure, a sample with
  // sample_valid=0 is neither a match nor a mismatch and leaves the hold count.
  logic [WIDTH-1:0] cur_val;
  logic [WIDTH-1:0] cur_mask;
  logic             hit;
  logic             accept;
  logic             final_acc;
  logic             timed_out;
  logic             len_bad;

  assign cur_val   = tab_val[step[AW-1:0]];
  assign cur_mask  = tab_mask[step[AW-1:0]];
  assign hit       = sample_valid && ((sample_in & cur_mask) == cur_val);
  assign accept    = hit && (hold_cnt == HOLD_LAST);
  assign final_acc = accept && (step == (len_q - SW'(1)));
  assign timed_out = (cycles == TO_LAST);
  assign len_bad   = (cfg_len == '0) || (cfg_len > DEPTH_L);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      fail_code <= 2'd0;
      step      <= '0;
      cycles    <= '0;
      hold_cnt  <= '0;
      len_q     <= '0;
    end else begin
      case (state)
        S_IDLE, S_PASS, S_FAIL: begin
          if (start) begin
            len_q    <= cfg_len;
            pass     <= 1'b0;
            step     <= '0;
            cycles   <= '0;
            hold_cnt <= '0;
            if (len_bad) begin
              state     <= S_FAIL;
              busy      <= 1'b0;
              fail      <= 1'b1;
              fail_code <= CODE_BADCFG;
            end else begin
              state     <= S_RUN;
              busy      <= 1'b1;
              fail      <= 1'b0;
              fail_code <= 2'd0;
            end
          end
        end

        S_RUN: begin
          // Exit cycles leave cycles untouched so it freezes at the exit index.
          if (abort) begin
            state     <= S_FAIL;
            busy      <= 1'b0;
            fail      <= 1'b1;
            fail_code <= CODE_ABORT;
          end else if (final_acc) begin
            state    <= S_PASS;
            busy     <= 1'b0;
            pass     <= 1'b1;
            step     <= step + SW'(1);
            hold_cnt <= '0;
          end else if (timed_out) begin
            state     <= S_FAIL;
            busy      <= 1'b0;
            fail      <= 1'b1;
            fail_code <= CODE_TIMEOUT;
          end else begin
            cycles <= cycles + CNT_W'(1);
            if (accept) begin
              step     <= step + SW'(1);
              hold_cnt <= '0;
            end else if (hit) begin
              hold_cnt <= hold_cnt + HW'(1);
            end else if (sample_valid) begin
              hold_cnt <= '0;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mprj_seq_monitor.sv
// Bench for mprj_seq_monitor: start-config vector table, hand-built traces for
// the multi-cycle corners, and random traces scored by a trace-scanning model.
module tb_mprj_seq_monitor;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int HOLD  = 2;
  localparam int CNT_W = 24;
  localparam int TO    = 100;

  logic              wb_clk_i;
  logic              wb_rst_i;
  logic              cfg_we;
  logic [2:0]        cfg_addr;
  logic [WIDTH-1:0]  cfg_value;
  logic [WIDTH-1:0]  cfg_mask;
  logic [3:0]        cfg_len;
  logic              start;
  logic              abort;
  logic [WIDTH-1:0]  sample_in;
  logic              sample_valid;
  logic              busy;
  logic              pass;
  logic              fail;
  logic [1:0]        fail_code;
  logic [3:0]        step;
  logic [CNT_W-1:0]  cycles;

  mprj_seq_monitor #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .HOLD    (HOLD),
    .CNT_W   (CNT_W),
    .TIMEOUT (24'd100)
  ) dut (
    .wb_clk_i     (wb_clk_i),
    .wb_rst_i     (wb_rst_i),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_value    (cfg_value),
    .cfg_mask     (cfg_mask),
    .cfg_len      (cfg_len),
    .start        (start),
    .abort        (abort),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .busy         (busy),
    .pass         (pass),
    .fail         (fail),
    .fail_code    (fail_code),
    .step         (step),
    .cycles       (cycles)
  );

  // ---------------- clock / reset ----------------
  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- types and scoreboard ----------------
  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] data;
    logic             abort;
    logic             we;
    logic [2:0]       waddr;
    logic [WIDTH-1:0] wval;
    logic [WIDTH-1:0] wmask;
  } cyc_t;

  typedef struct packed {
    logic             pass;
    logic             fail;
    logic [1:0]       code;
    logic [3:0]       step;
    logic [CNT_W-1:0] cycles;
  } res_t;

  typedef struct packed {
    logic [3:0] len;
    logic       exp_busy;
    logic       exp_fail;
    logic [1:0] exp_code;
  } sv_t;

  int               n_checks = 0;
  int               n_pass   = 0;
  logic [31:0]      exp_q[$];
  cyc_t             tr[$];
  logic [WIDTH-1:0] m_val  [DEPTH];
  logic [WIDTH-1:0] m_mask [DEPTH];
  logic [WIDTH-1:0] t_val  [5];
  logic [WIDTH-1:0] t_mask [5];
  logic [31:0]      last_exp;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    else n_pass++;
  endtask

  function automatic logic [31:0] dut_result();
    res_t g;
    g.pass   = pass;
    g.fail   = fail;
    g.code   = fail_code;
    g.step   = step;
    g.cycles = cycles;
    return g;
  endfunction

  // Reference: walk the per-cycle trace applying the checkpoint rules directly.
  function automatic void predict(input int len, output res_t r, output int ek);
    int   s;
    int   run;
    logic m;
    s   = 0;
    run = 0;
    r   = '0;
    ek  = -1;
    for (int k = 0; k < tr.size(); k++) begin
      m = tr[k].valid && ((tr[k].data & m_mask[s]) == m_val[s]);
      if (tr[k].abort) begin
        r.fail = 1'b1; r.code = 2'd2; r.step = 4'(s); r.cycles = 24'(k); ek = k;
        break;
      end else if (m && (run + 1 == HOLD) && (s + 1 == len)) begin
        r.pass = 1'b1; r.step = 4'(len); r.cycles = 24'(k); ek = k;
        break;
      end else if (k == TO - 1) begin
        r.fail = 1'b1; r.code = 2'd1; r.step = 4'(s); r.cycles = 24'(k); ek = k;
        break;
      end else if (m) begin
        run++;
        if (run == HOLD) begin
          s++;
          run = 0;
        end
      end else if (tr[k].valid) begin
        run = 0;
      end
    end
    if (ek < 0) begin
      r.step   = 4'(s);
      r.cycles = 24'(tr.size());
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    cfg_we = 1'b0; cfg_addr = '0; cfg_value = '0; cfg_mask = '0;
    start = 1'b0; abort = 1'b0; sample_in = '0; sample_valid = 1'b0;
  endtask

  task automatic do_reset();
    wb_rst_i = 1'b1;
    tick();
    wb_rst_i = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"},      32'(busy),      32'd0);
    check({tag, "_pass"},      32'(pass),      32'd0);
    check({tag, "_fail"},      32'(fail),      32'd0);
    check({tag, "_fail_code"}, 32'(fail_code), 32'd0);
    check({tag, "_step"},      32'(step),      32'd0);
    check({tag, "_cycles"},    32'(cycles),    32'd0);
  endtask

  task automatic write_entry(input int a, input logic [WIDTH-1:0] v, input logic [WIDTH-1:0] m);
    cfg_we = 1'b1; cfg_addr = 3'(a); cfg_value = v; cfg_mask = m;
    tick();
    cfg_we = 1'b0;
    m_val[a]  = v & m;
    m_mask[a] = m;
  endtask

  task automatic program_table();
    for (int i = 0; i < 5; i++) write_entry(i, t_val[i], t_mask[i]);
  endtask

  task automatic add(input logic v, input logic [WIDTH-1:0] d, input logic ab);
    cyc_t c;
    c = '0;
    c.valid = v;
    c.data  = d;
    c.abort = ab;
    tr.push_back(c);
  endtask

  task automatic build_full();
    tr.delete();
    for (int i = 0; i < 5; i++) begin
      add(1'b1, t_val[i], 1'b0);
      add(1'b1, t_val[i], 1'b0);
    end
  endtask

  task automatic run_trace(input string tag, input int len);
    res_t r;
    int   ek;
    predict(len, r, ek);
    exp_q.push_back(r);
    cfg_len = 4'(len);
    start   = 1'b1;
    tick();
    start   = 1'b0;
    check({tag, "_busy_start"}, 32'(busy), 32'd1);
    for (int k = 0; k < tr.size(); k++) begin
      sample_valid = tr[k].valid;
      sample_in    = tr[k].data;
      abort        = tr[k].abort;
      cfg_we       = tr[k].we;
      cfg_addr     = tr[k].waddr;
      cfg_value    = tr[k].wval;
      cfg_mask     = tr[k].wmask;
      tick();
      if (k == ek) break;
    end
    idle_inputs();
    check({tag, "_busy_end"}, 32'(busy), (ek < 0) ? 32'd1 : 32'd0);
    last_exp = exp_q.pop_front();
    check({tag, "_result"}, dut_result(), last_exp);
  endtask

  // ---------------- test sequence ----------------
  sv_t svec[5];

  initial begin
    t_val[0] = 16'hAB40; t_mask[0] = 16'hFFFF;
    t_val[1] = 16'h000A; t_mask[1] = 16'h000F;
    t_val[2] = 16'h0005; t_mask[2] = 16'h000F;
    t_val[3] = 16'h0009; t_mask[3] = 16'hFFFF;
    t_val[4] = 16'hAB51; t_mask[4] = 16'hFFFF;
    svec[0] = '{len: 4'd0,  exp_busy: 1'b0, exp_fail: 1'b1, exp_code: 2'd3};
    svec[1] = '{len: 4'd9,  exp_busy: 1'b0, exp_fail: 1'b1, exp_code: 2'd3};
    svec[2] = '{len: 4'd15, exp_busy: 1'b0, exp_fail: 1'b1, exp_code: 2'd3};
    svec[3] = '{len: 4'd8,  exp_busy: 1'b1, exp_fail: 1'b0, exp_code: 2'd0};
    svec[4] = '{len: 4'd1,  exp_busy: 1'b1, exp_fail: 1'b0, exp_code: 2'd0};

    idle_inputs();
    cfg_len  = '0;
    wb_rst_i = 1'b1;
    tick();
    do_reset();
    check_zero("reset");

    // In-order sequence passes, then outputs stay frozen under new samples.
    program_table();
    build_full();
    run_trace("full_pass", 5);
    for (int i = 0; i < 3; i++) begin
      sample_valid = 1'b1;
      sample_in    = 16'(i);
      tick();
    end
    idle_inputs();
    check("pass_frozen", dut_result(), last_exp);

    // Masked compare ignores unmasked bits of the field.
    build_full();
    tr[2].data = 16'hF0FA;
    tr[3].data = 16'h123A;
    run_trace("masked_pass", 5);

    // Mismatch clears the hold count; invalid gaps keep it.
    do_reset();
    tr.delete();
    add(1'b1, 16'hAB40, 1'b0); add(1'b1, 16'h1234, 1'b0); add(1'b1, 16'hAB40, 1'b0);
    run_trace("hold_clear", 5);
    do_reset();
    add(1'b1, 16'hAB40, 1'b0);
    run_trace("hold_clear_accept", 5);
    do_reset();
    tr.delete();
    add(1'b1, 16'hAB40, 1'b0); add(1'b0, 16'h1234, 1'b0); add(1'b0, 16'h0000, 1'b0);
    add(1'b1, 16'hAB40, 1'b0);
    run_trace("gap_hold", 5);
    do_reset();

    // Timeout, final accept on the last budget cycle, and one cycle too late.
    tr.delete();
    for (int i = 0; i < TO; i++) add(1'b1, 16'h1111, 1'b0);
    run_trace("timeout", 5);
    tr.delete();
    for (int i = 0; i < TO - 10; i++) add(1'b0, 16'hAB40, 1'b0);
    for (int i = 0; i < 5; i++) begin
      add(1'b1, t_val[i], 1'b0);
      add(1'b1, t_val[i], 1'b0);
    end
    run_trace("accept_last_cycle", 5);
    tr.delete();
    for (int i = 0; i < TO - 9; i++) add(1'b0, 16'hAB40, 1'b0);
    for (int i = 0; i < 5; i++) begin
      add(1'b1, t_val[i], 1'b0);
      add(1'b1, t_val[i], 1'b0);
    end
    run_trace("accept_too_late", 5);

    // Abort at step 2 with a table write attempted mid-run.
    build_full();
    tr[3].we = 1'b1; tr[3].waddr = 3'd0; tr[3].wval = 16'hFFFF; tr[3].wmask = 16'hFFFF;
    tr[4].abort = 1'b1;
    run_trace("abort_step2", 5);
    build_full();
    run_trace("table_kept_after_run_write", 5);
    build_full();
    tr[9].abort = 1'b1;
    run_trace("abort_beats_pass", 5);

    // Start-time configuration vectors.
    for (int i = 0; i < 5; i++) begin
      cfg_len = svec[i].len;
      start   = 1'b1;
      tick();
      start   = 1'b0;
      check($sformatf("cfg%0d_busy", i), 32'(busy), 32'(svec[i].exp_busy));
      check($sformatf("cfg%0d_fail", i), 32'(fail), 32'(svec[i].exp_fail));
      check($sformatf("cfg%0d_code", i), 32'(fail_code), 32'(svec[i].exp_code));
      if (svec[i].exp_busy) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check($sformatf("cfg%0d_abort_code", i), 32'(fail_code), 32'd2);
      end else begin
        tick();
        check($sformatf("cfg%0d_busy_later", i), 32'(busy), 32'd0);
      end
    end

    // Reset mid-run at step 3, then rerun without reprogramming.
    build_full();
    void'(tr.pop_back()); void'(tr.pop_back());
    void'(tr.pop_back()); void'(tr.pop_back());
    run_trace("pre_reset", 5);
    do_reset();
    check_zero("mid_reset");
    build_full();
    run_trace("after_reset", 5);

    // Randomised tables and traces.
    for (int rnd = 0; rnd < 25; rnd++) begin
      int len;
      for (int i = 0; i < DEPTH; i++) begin
        logic [WIDTH-1:0] mk;
        case ($urandom_range(0, 3))
          0:       mk = 16'h0000;
          1:       mk = 16'hFFFF;
          default: mk = 16'($urandom);
        endcase
        write_entry(i, 16'($urandom), mk);
      end
      len = $urandom_range(1, DEPTH);
      tr.delete();
      for (int i = 0; i < len; i++) begin
        int j;
        j = 0;
        while (j < HOLD && tr.size() < 130) begin
          int  rr;
          logic ab;
          rr = $urandom_range(0, 9);
          ab = ($urandom_range(0, 199) == 0);
          if (rr < 2) add(1'b0, 16'($urandom), ab);
          else if (rr < 3) begin
            add(1'b1, 16'($urandom), ab);
            j = 0;
          end else begin
            add(1'b1, m_val[i] | (16'($urandom) & ~m_mask[i]), ab);
            j++;
          end
        end
      end
      while (tr.size() < TO) add(1'b0, 16'($urandom), 1'b0);
      for (int k = 0; k < tr.size(); k++) begin
        if ($urandom_range(0, 7) == 0) begin
          tr[k].we    = 1'b1;
          tr[k].waddr = 3'($urandom);
          tr[k].wval  = 16'($urandom);
          tr[k].wmask = 16'($urandom);
        end
      end
      run_trace($sformatf("rand%0d", rnd), len);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mprj_seq_monitor.md
Name: mprj_seq_monitor

Overview:
- Parametrised on-chip checkpoint-sequence monitor for a user-project GPIO field.
- Watches a WIDTH-bit sampled bus and matches it in order against a programmed table of up to DEPTH (value, mask) checkpoints.
- Each checkpoint must be held for HOLD consecutive valid samples; a global cycle budget applies to the whole sequence.
- Reports sticky pass/fail, fail cause, current step and elapsed cycles. Sits in the user project area beside the mprj_io pads, as a self-checking debug aid for silicon bring-up.

Parameters:
- WIDTH, 16, width of monitored field and of each table value/mask.
- DEPTH, 8, number of checkpoint table entries (power of 2, >=2).
- HOLD, 2, consecutive matching valid samples required to accept a checkpoint (>=1).
- CNT_W, 24, width of cycle counter.
- TIMEOUT, 24'd150000, cycle budget from start to completion (<= 2^CNT_W-1).

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  synchronous active-high reset
- cfg_we  in  1  table write strobe
- cfg_addr  in  $clog2(DEPTH)  table entry index
- cfg_value  in  WIDTH  expected value
- cfg_mask  in  WIDTH  compare mask (1 = bit compared)
- cfg_len  in  $clog2(DEPTH)+1  number of active checkpoints, sampled at start
- start  in  1  arm/re-arm pulse
- abort  in  1  force fail
- sample_in  in  WIDTH  monitored bus (already synchronised upstream)
- sample_valid  in  1  sample qualifier
- busy  out  1  high in RUN
- pass  out  1  sticky pass
- fail  out  1  sticky fail
- fail_code  out  2  0 none, 1 timeout, 2 abort, 3 bad config
- step  out  $clog2(DEPTH)+1  index of checkpoint being sought
- cycles  out  CNT_W  cycles elapsed in RUN (frozen at exit)

Behaviour:
- Reset (sync, wb_rst_i=1 at posedge): state IDLE; busy=0, pass=0, fail=0, fail_code=0, step=0, cycles=0, hold count=0, latched length=0. Table contents not reset; retained across wb_rst_i.
- Table write:
  - cfg_we=1 writes entry[cfg_addr] at posedge in IDLE, PASS or FAIL.
  - Writes ignored in RUN.
  - Entry stored as value&mask.
- States: IDLE, RUN, PASS, FAIL.
- IDLE/PASS/FAIL + start:
  - Latches cfg_len.
  - If cfg_len==0 or cfg_len>DEPTH: go to FAIL, fail_code=3, next cycle.
  - Otherwise: go to RUN; clear step, cycles, hold count, pass, fail and fail_code.
  - busy=1 from the cycle after start.
- RUN:
  - Per cycle: cycles increments by 1.
  - Match = sample_valid & ((sample_in & mask[step]) == value[step]).
    - Match: hold count increments.
    - Valid non-match: hold count clears.
    - sample_valid=0: hold count holds.
  - Hold count reaching HOLD accepts the checkpoint: step increments and hold count clears.
  - Acceptance of step len-1: go to PASS, pass=1, busy=0 next cycle; step = len.
  - Timeout: cycles == TIMEOUT-1 without final acceptance -> FAIL, fail_code=1.
  - Same-cycle final acceptance and timeout: PASS wins.
  - abort=1: FAIL, fail_code=2.
  - Priority abort > pass > timeout.
  - start during RUN: ignored.
- PASS/FAIL: outputs frozen (step and cycles included) until start or reset.
- Checkpoint acceptance latency: HOLD valid matching cycles; pass asserted 1 cycle after the final accepting sample.
- Reset mid-RUN: immediate IDLE with all outputs cleared; no pass/fail pulse.
- Counter never wraps: TIMEOUT bounds it.

Test Plan:
- WIDTH=16, HOLD=2; table [AB40/FFFF, 000A/000F, 0005/000F, 0009/FFFF, AB51/FFFF], len=5; drive each value 2 valid cycles, in order -> pass=1, fail=0, step=5, busy=0 one cycle after last sample.
- Same table; drive AB40 for 1 cycle then 1234, then AB40 for 2 cycles -> step stays 0 until the second run, then 1 (hold-count clear on mismatch); valid=0 gaps mid-hold do not reset the count.
- TIMEOUT=100, table never matched -> fail=1, fail_code=1, cycles=99 frozen; final accept on cycle 99 instead -> pass=1, fail=0.
- abort asserted at step 2 -> fail_code=2, step=2; cfg_we in RUN to entry 0 is ignored (verify by readback via a re-run).
- start with cfg_len=0 and with cfg_len=9 (DEPTH=8) -> fail_code=3, busy never asserted.
- wb_rst_i pulsed mid-RUN at step 3 -> all outputs 0 next cycle; start again without reprogramming -> sequence passes (table retained).
